// File: rtl/button_event_unit.sv
// button_event_unit: turns debounced button levels into one-cycle events.
//  - reset button: rising edge -> reset_pulse (and clears any walk request)
//  - walk button: rising edge -> latched walk_pending until walk_ack;
//    a press while a request is outstanding flags walk_dropped
//  - reprogram button: rising edge -> reprog_pulse, or, with the
//    REPROG_LONG_PRESS_EN macro defined, a single pulse after the button
//    has been held for HOLD_CYCLES consecutive cycles.
// All outputs are registered. Reset is synchronous and active-high.
module button_event_unit #(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic clk,
  input  logic sys_reset,
  input  logic reset_db_in,
  input  logic walk_db_in,
  input  logic reprog_db_in,
  input  logic walk_ack,
  output logic reset_pulse,
  output logic walk_pending,
  output logic reprog_pulse,
  output logic walk_dropped
);

  // Catch a hold counter too narrow to ever reach the hold target.
  if (HOLD_CYCLES == 0 || (64'(1) << CNT_W) <= 64'(HOLD_CYCLES)) begin : g_cfg_check
    $error("button_event_unit: need HOLD_CYCLES > 0 and 2**CNT_W > HOLD_CYCLES");
  end

  logic reset_prev_q;
  logic walk_prev_q;
  logic reset_pulse_q, reset_pulse_d;
  logic walk_pending_q, walk_pending_d;
  logic walk_dropped_q, walk_dropped_d;
  logic reprog_pulse_q, reprog_pulse_d;
  logic reset_edge;
  logic walk_edge;

  assign reset_edge = reset_db_in & ~reset_prev_q;
  assign walk_edge  = walk_db_in & ~walk_prev_q;

`ifdef REPROG_LONG_PRESS_EN
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             armed_q, armed_d;

  // Hold counter: runs while armed and held, saturates at the target,
  // and fires exactly once on the step that reaches the target.
  always_comb begin
    armed_d        = armed_q | ~reprog_db_in;
    hold_cnt_d     = hold_cnt_q;
    reprog_pulse_d = 1'b0;
    if (!reprog_db_in) begin
      hold_cnt_d = '0;
    end else if (armed_q && hold_cnt_q != CNT_W'(HOLD_CYCLES)) begin
      hold_cnt_d     = hold_cnt_q + CNT_W'(1);
      reprog_pulse_d = (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1));
    end
  end
`else
  logic reprog_prev_q;

  // Short-press mode: reprogram behaves like the reset button.
  always_comb begin
    reprog_pulse_d = reprog_db_in & ~reprog_prev_q;
  end
`endif

  // Event decode and walk-request latch; reset edge beats walk set, set beats ack.
  always_comb begin
    reset_pulse_d  = reset_edge;
    walk_dropped_d = walk_edge & walk_pending_q & ~walk_ack;
    walk_pending_d = walk_pending_q;
    if (reset_edge) begin
      walk_pending_d = 1'b0;
    end else if (walk_edge) begin
      walk_pending_d = 1'b1;
    end else if (walk_ack) begin
      walk_pending_d = 1'b0;
    end
  end

  // State and output registers; previous samples reset high so a button
  // held through reset must be released before it can generate an event.
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      reset_prev_q   <= 1'b1;
      walk_prev_q    <= 1'b1;
      reset_pulse_q  <= 1'b0;
      walk_pending_q <= 1'b0;
      walk_dropped_q <= 1'b0;
      reprog_pulse_q <= 1'b0;
`ifdef REPROG_LONG_PRESS_EN
      hold_cnt_q     <= '0;
      armed_q        <= 1'b0;
`else
      reprog_prev_q  <= 1'b1;
`endif
    end else begin
      reset_prev_q   <= reset_db_in;
      walk_prev_q    <= walk_db_in;
      reset_pulse_q  <= reset_pulse_d;
      walk_pending_q <= walk_pending_d;
      walk_dropped_q <= walk_dropped_d;
      reprog_pulse_q <= reprog_pulse_d;
`ifdef REPROG_LONG_PRESS_EN
      hold_cnt_q     <= hold_cnt_d;
      armed_q        <= armed_d;
`else
      reprog_prev_q  <= reprog_db_in;
`endif
    end
  end

  assign reset_pulse  = reset_pulse_q;
  assign walk_pending = walk_pending_q;
  assign reprog_pulse = reprog_pulse_q;
  assign walk_dropped = walk_dropped_q;

endmodule

// File: doc/button_event_unit.md
BUTTON_EVENT_UNIT -- requirements
Module: button_event_unit

Interface
REQ-001 Parameter HOLD_CYCLES, default 50000000, sets the consecutive high cycles of reprog_db_in needed for a reprogram event (long-press mode only).
REQ-002 Parameter CNT_W, default 26, is the hold counter width; it SHALL satisfy 2**CNT_W > HOLD_CYCLES.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 sys_reset  input  1  reset, synchronous and active-high.
REQ-005 reset_db_in  input  1  debounced reset button level.
REQ-006 walk_db_in  input  1  debounced walk-request button level.
REQ-007 reprog_db_in  input  1  debounced reprogram button level.
REQ-008 walk_ack  input  1  one-cycle acknowledge from the light FSM that the walk phase was granted.
REQ-009 reset_pulse  output  1  one-cycle controller-reset event.
REQ-010 walk_pending  output  1  latched walk request, held until acknowledged.
REQ-011 reprog_pulse  output  1  one-cycle reprogram event.
REQ-012 walk_dropped  output  1  one-cycle flag: a walk press arrived while a request was already pending.

Function
REQ-013 Each *_db_in SHALL be registered into a previous-sample register; a rising edge is current=1 and previous=0.
REQ-014 reset_pulse SHALL go high for exactly one cycle, one cycle after the clock edge that samples the reset_db_in rising edge.
REQ-015 A walk_db_in rising edge SHALL set walk_pending on the next cycle; walk_pending SHALL stay high until cleared.
REQ-016 walk_ack while walk_pending=1 SHALL clear walk_pending on the next cycle; walk_ack while walk_pending=0 SHALL have no effect.
REQ-017 A walk edge and walk_ack in the same cycle SHALL leave walk_pending=1, with set taking priority over clear, and walk_dropped=0.
REQ-018 A walk edge while walk_pending=1 and walk_ack=0 SHALL leave walk_pending=1 and pulse walk_dropped for one cycle.
REQ-019 A reset_db_in rising edge SHALL clear walk_pending on the next cycle, with priority over any set in that cycle.
REQ-020 A reprogram event SHALL NOT change walk_pending.
REQ-021 Hold counter: counts while reprog_db_in=1, saturates at HOLD_CYCLES, and returns to 0 in the cycle after reprog_db_in=0.
REQ-022 Each button's events SHALL be independent; simultaneous edges on different buttons SHALL each produce their own event in the same cycle.
REQ-023 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-024 On sys_reset=1 at a clock edge: reset_pulse=0, walk_pending=0, reprog_pulse=0, walk_dropped=0, hold counter=0.
REQ-025 Reset SHALL set all previous-sample registers to 1 and clear the reprogram armed flag, so a button held through reset produces no event until released and pressed again.
REQ-026 Reset asserted mid-hold or with a request pending SHALL abort all activity; no pulse SHALL be emitted in the cycle after reset deasserts.
REQ-027 The armed flag SHALL set in any cycle where reprog_db_in=0; the hold counter SHALL count only while the flag is set.

Configuration
REQ-028 Macro REPROG_LONG_PRESS_EN selects the reprogram detection mode.
REQ-029 With REPROG_LONG_PRESS_EN defined: reprog_pulse fires once, in the cycle after the counter reaches HOLD_CYCLES.
REQ-030 With it defined: no further pulse SHALL fire until the button is released and a new full hold completes.
REQ-031 With it defined: releasing the button before HOLD_CYCLES SHALL produce no pulse.
REQ-032 Without REPROG_LONG_PRESS_EN: reprog_pulse SHALL behave exactly like reset_pulse (one cycle, rising-edge triggered), the hold counter SHALL be absent, and HOLD_CYCLES and CNT_W SHALL be ignored.

Verification (HOLD_CYCLES=4)
REQ-033 Reset, then walk_db_in 0->1 at cycle 10 -> walk_pending=1 from cycle 11; walk_ack at cycle 20 -> walk_pending=0 at cycle 21.
REQ-034 walk_pending=1, second walk edge at cycle 30 -> walk_dropped=1 only in cycle 31; walk_pending stays 1.
REQ-035 Walk edge and walk_ack in the same cycle 40 -> walk_pending=1 at cycle 41; walk_dropped=0.
REQ-036 Long press defined, reprog_db_in high for 3 cycles -> no pulse; high for 10 cycles -> exactly one reprog_pulse, in the cycle after the 4th high sample.
REQ-037 walk_db_in and reprog_db_in held high across sys_reset -> no walk_pending and no reprog_pulse until each is released and pressed again.
REQ-038 reset_db_in rising edge with walk_pending=1 -> reset_pulse=1 for one cycle and walk_pending=0 in that same cycle.
